// File: rtl/bus_pkg.sv
// Shared encodings for the IFU/LSU memory bus arbiter: FSM states, grant IDs
// and default bus widths.
package bus_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RSP  = 2'd2;
  localparam state_t ST_ERR  = 2'd3;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Valid/ready memory bus with a request channel and a response channel.
// The master modport issues requests; the slave modport answers them.
interface mem_bus_arbiter_if #(
  parameter int AW = bus_pkg::DEF_AW,
  parameter int DW = bus_pkg::DEF_DW
);

  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   addr;
  logic            wen;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rdata;
  logic            rsp_err;

  modport master (
    output req_valid, addr, wen, wdata, wmask, rsp_ready,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wmask, rsp_ready,
    output req_ready, rsp_valid, rdata, rsp_err
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, on a tie the master
// that did not finish the previous transaction wins.
module rr_pick2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = GNT_IFU;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req[1]) begin
      grant = GNT_LSU;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory slave between instruction fetch (m0) and load/store (m1),
// one outstanding transaction at a time, with an optional response timeout.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 0
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  mem_bus_arbiter_if.master s
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state_reg, state_next;
  logic            grant_reg, last_reg, pick;
  logic [AW-1:0]   addr_reg;
  logic            wen_reg;
  logic [DW-1:0]   wdata_reg;
  logic [DW/8-1:0] wmask_reg;

  logic            accept, g_rsp_ready, rsp_done, tmo_hit;
  logic            rsp_vld, rsp_err;
  logic [DW-1:0]   rsp_data;

  rr_pick2 u_pick (
    .req   ({m1.req_valid, m0.req_valid}),
    .last  (last_reg),
    .grant (pick)
  );

  // Gated by rst so no ready is offered while reset is held.
  assign accept      = rst && (state_reg == ST_IDLE) && (m0.req_valid || m1.req_valid);
  assign g_rsp_ready = (grant_reg == GNT_LSU) ? m1.rsp_ready : m0.rsp_ready;
  assign rsp_done    = (state_reg == ST_RSP) && s.rsp_valid && g_rsp_ready;

  generate
    if (TIMEOUT > 0) begin : g_tmo
      logic [TW-1:0] tmo_cnt_reg;

      // Expiring on TIMEOUT-1 lands in ERR exactly TIMEOUT cycles after REQ entry.
      assign tmo_hit = (tmo_cnt_reg == TW'(TIMEOUT - 1));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tmo_cnt_reg <= '0;
        end else if (accept) begin
          tmo_cnt_reg <= '0;
        end else if (state_reg == ST_REQ || state_reg == ST_RSP) begin
          tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
      end
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_REQ;
      ST_REQ: begin
        if (tmo_hit)          state_next = ST_ERR;
        else if (s.req_ready) state_next = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_done)     state_next = ST_IDLE;
        else if (tmo_hit) state_next = ST_ERR;
      end
      default: if (g_rsp_ready) state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      grant_reg <= GNT_IFU;
      last_reg  <= GNT_LSU;
      addr_reg  <= '0;
      wen_reg   <= 1'b0;
      wdata_reg <= '0;
      wmask_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        grant_reg <= pick;
        addr_reg  <= (pick == GNT_LSU) ? m1.addr  : m0.addr;
        wen_reg   <= (pick == GNT_LSU) ? m1.wen   : m0.wen;
        wdata_reg <= (pick == GNT_LSU) ? m1.wdata : m0.wdata;
        wmask_reg <= (pick == GNT_LSU) ? m1.wmask : m0.wmask;
      end
      if (rsp_done || (state_reg == ST_ERR && g_rsp_ready)) begin
        last_reg <= grant_reg;
      end
    end
  end

  // Response seen by the granted master: slave pass-through, or a synthetic error.
  always_comb begin
    rsp_vld  = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    if (state_reg == ST_RSP) begin
      rsp_vld  = s.rsp_valid;
      rsp_err  = s.rsp_err;
      rsp_data = s.rdata;
    end else if (state_reg == ST_ERR) begin
      rsp_vld = 1'b1;
      rsp_err = 1'b1;
    end
  end

  assign m0.req_ready = accept && (pick == GNT_IFU);
  assign m1.req_ready = accept && (pick == GNT_LSU);
  assign m0.rsp_valid = rsp_vld && (grant_reg == GNT_IFU);
  assign m1.rsp_valid = rsp_vld && (grant_reg == GNT_LSU);
  assign m0.rsp_err   = rsp_err && (grant_reg == GNT_IFU);
  assign m1.rsp_err   = rsp_err && (grant_reg == GNT_LSU);
  assign m0.rdata     = (grant_reg == GNT_IFU) ? rsp_data : '0;
  assign m1.rdata     = (grant_reg == GNT_LSU) ? rsp_data : '0;

  assign s.req_valid  = (state_reg == ST_REQ);
  assign s.addr       = addr_reg;
  assign s.wen        = wen_reg;
  assign s.wdata      = wdata_reg;
  assign s.wmask      = wmask_reg;
  assign s.rsp_ready  = (state_reg == ST_ERR) || (state_reg == ST_RSP && g_rsp_ready);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a vector table for the arbitration and
// pass-through cycles, plus hand sequences for stall, timeout, back-pressure and reset.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) m0_if ();
  mem_bus_arbiter_if #(.AW(32), .DW(32)) m1_if ();
  mem_bus_arbiter_if #(.AW(32), .DW(32)) s_if ();

  mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  // Flag bit positions: {m0_req_ready, m1_req_ready, s_req_valid, s_rsp_ready,
  //                      m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err}
  localparam logic [7:0] F_M0RR = 8'h80, F_M1RR = 8'h40, F_SRV = 8'h20, F_SRR = 8'h10;
  localparam logic [7:0] F_M0V  = 8'h08, F_M1V  = 8'h04, F_M0E = 8'h02, F_M1E = 8'h01;

  typedef struct {
    bit          m0r, m1r, m0a, m1a, sqr, srv;
    logic [31:0] rd;
    bit          se;
    logic [7:0]  f;
    logic [95:0] d;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(bit m0r, bit m1r, bit m0a, bit m1a, bit sqr, bit srv,
                              logic [31:0] rd, bit se, logic [7:0] f,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] sa);
    vec_t v;
    v.m0r = m0r; v.m1r = m1r; v.m0a = m0a; v.m1a = m1a; v.sqr = sqr; v.srv = srv;
    v.rd = rd; v.se = se; v.f = f; v.d = {d0, d1, sa};
    return v;
  endfunction

  function automatic logic [7:0] flags();
    return {m0_if.req_ready, m1_if.req_ready, s_if.req_valid, s_if.rsp_ready,
            m0_if.rsp_valid, m1_if.rsp_valid, m0_if.rsp_err, m1_if.rsp_err};
  endfunction

  function automatic logic [95:0] data();
    return {m0_if.rdata, m1_if.rdata, s_if.addr};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else begin
      passed++;
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive(input bit m0r, input bit m1r, input bit m0a, input bit m1a,
                       input bit sqr, input bit srv, input logic [31:0] rd, input bit se);
    m0_if.req_valid = m0r;
    m1_if.req_valid = m1r;
    m0_if.rsp_ready = m0a;
    m1_if.rsp_ready = m1a;
    s_if.req_ready  = sqr;
    s_if.rsp_valid  = srv;
    s_if.rdata      = rd;
    s_if.rsp_err    = se;
  endtask

  task automatic m1_fields(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] wm);
    m1_if.addr = a; m1_if.wen = w; m1_if.wdata = wd; m1_if.wmask = wm;
  endtask

  initial begin
    // Tie sequence after reset: grants 0,1,0,1; then a lone m0 read and a stray response.
    vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 0, 8'h00, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(1,1,0,0,0,0, 32'h0, 0, F_M0RR, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk(1,1,0,0,1,0, 32'h0, 0, F_SRV, 32'h0, 32'h0, 32'h80000000));
    vecs.push_back(mk(1,1,1,1,0,1, 32'h11111111, 0, F_SRR|F_M0V, 32'h11111111, 32'h0, 32'h80000000));
    vecs.push_back(mk(1,1,0,0,0,0, 32'h0, 0, F_M1RR, 32'h0, 32'h0, 32'h80000000));
    vecs.push_back(mk(1,1,0,0,1,0, 32'h0, 0, F_SRV, 32'h0, 32'h0, 32'h80001000));
    vecs.push_back(mk(1,1,1,1,0,1, 32'h22222222, 0, F_SRR|F_M1V, 32'h0, 32'h22222222, 32'h80001000));
    vecs.push_back(mk(1,1,0,0,0,0, 32'h0, 0, F_M0RR, 32'h0, 32'h0, 32'h80001000));
    vecs.push_back(mk(1,1,0,0,1,0, 32'h0, 0, F_SRV, 32'h0, 32'h0, 32'h80000000));
    vecs.push_back(mk(1,1,1,1,0,1, 32'h33333333, 0, F_SRR|F_M0V, 32'h33333333, 32'h0, 32'h80000000));
    vecs.push_back(mk(1,1,0,0,0,0, 32'h0, 0, F_M1RR, 32'h0, 32'h0, 32'h80000000));
    vecs.push_back(mk(1,1,0,0,1,0, 32'h0, 0, F_SRV, 32'h0, 32'h0, 32'h80001000));
    vecs.push_back(mk(1,1,1,1,0,1, 32'h44444444, 1, F_SRR|F_M1V|F_M1E, 32'h0, 32'h44444444, 32'h80001000));
    vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 0, 8'h00, 32'h0, 32'h0, 32'h80001000));
    vecs.push_back(mk(1,0,0,0,0,0, 32'h0, 0, F_M0RR, 32'h0, 32'h0, 32'h80001000));
    vecs.push_back(mk(0,0,0,0,1,0, 32'h0, 0, F_SRV, 32'h0, 32'h0, 32'h80000000));
    vecs.push_back(mk(0,0,1,1,0,1, 32'hDEADBEEF, 0, F_SRR|F_M0V, 32'hDEADBEEF, 32'h0, 32'h80000000));
    vecs.push_back(mk(0,0,1,1,0,1, 32'hBAD0BAD0, 1, 8'h00, 32'h0, 32'h0, 32'h80000000));

    m0_if.addr = 32'h80000000; m0_if.wen = 1'b0; m0_if.wdata = 32'h0; m0_if.wmask = 4'h0;
    m1_fields(32'h80001000, 1'b1, 32'h12345678, 4'b0011);

    // Reset held with a pending request: nothing may be offered.
    rst = 1'b0;
    drive(1,0,0,0,0,0, 32'h0, 0);
    @(negedge clk); @(negedge clk); #1;
    check("reset_flags", flags(), 8'h00);
    check("reset_data", data(), 96'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(0,0,0,0,0,0, 32'h0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].m0r, vecs[i].m1r, vecs[i].m0a, vecs[i].m1a,
            vecs[i].sqr, vecs[i].srv, vecs[i].rd, vecs[i].se);
      #1;
      check($sformatf("vec%0d_flags", i), flags(), vecs[i].f);
      check($sformatf("vec%0d_data", i), data(), vecs[i].d);
    end

    // m1 write with the slave stalling 5 cycles; m1 scribbles its fields meanwhile.
    @(negedge clk); drive(0,1,0,0,0,0, 32'h0, 0); #1;
    check("stall_accept", flags(), F_M1RR);
    @(negedge clk);
    m1_fields(32'hFFFFFFFF, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      drive(0,0,0,0,0,0, 32'h0, 0); #1;
      check($sformatf("stall_hold%0d", i),
            {s_if.req_valid, s_if.addr, s_if.wen, s_if.wdata, s_if.wmask},
            {1'b1, 32'h80001000, 1'b1, 32'h12345678, 4'b0011});
    end
    @(negedge clk); drive(0,0,0,0,1,0, 32'h0, 0); #1;
    check("stall_go", flags(), F_SRV);
    @(negedge clk); drive(0,0,0,1,0,1, 32'h600DF00D, 0); #1;
    check("stall_rsp", flags(), F_SRR|F_M1V);
    check("stall_rdata", data(), {32'h0, 32'h600DF00D, 32'h80001000});
    m1_fields(32'h80001000, 1'b1, 32'h12345678, 4'b0011);
    @(negedge clk); drive(0,0,0,0,0,0, 32'h0, 0); #1;
    check("stall_idle", flags(), 8'h00);

    // m0 read that the slave never accepts: ERR after exactly 8 REQ cycles.
    @(negedge clk); drive(1,0,0,0,0,0, 32'h0, 0); #1;
    check("tmo_accept", flags(), F_M0RR);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(0,0,0,0,0,0, 32'h0, 0); #1;
      check($sformatf("tmo_wait%0d", i), flags(), F_SRV);
    end
    @(negedge clk); drive(0,0,0,0,0,0, 32'h0, 0); #1;
    check("tmo_err", flags(), F_SRR|F_M0V|F_M0E);
    check("tmo_rdata", data(), {32'h0, 32'h0, 32'h80000000});
    @(negedge clk); drive(0,0,1,0,0,0, 32'h0, 0); #1;
    check("tmo_err_hold", flags(), F_SRR|F_M0V|F_M0E);
    @(negedge clk); drive(0,0,0,0,0,0, 32'h0, 0); #1;
    check("tmo_idle", flags(), 8'h00);

    // m0 holds off its response for 3 cycles; slave must see no ready.
    @(negedge clk); drive(1,0,0,0,0,0, 32'h0, 0); #1;
    check("bp_accept", flags(), F_M0RR);
    @(negedge clk); drive(0,0,0,0,1,0, 32'h0, 0); #1;
    check("bp_req", flags(), F_SRV);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0,0,0,0,0,1, 32'hCAFEF00D, 0); #1;
      check($sformatf("bp_hold%0d", i), flags(), F_M0V);
    end
    @(negedge clk); drive(0,0,1,0,0,1, 32'hCAFEF00D, 0); #1;
    check("bp_done", flags(), F_SRR|F_M0V);
    check("bp_rdata", data(), {32'hCAFEF00D, 32'h0, 32'h80000000});
    @(negedge clk); drive(0,0,0,0,0,0, 32'h0, 0); #1;
    check("bp_idle", flags(), 8'h00);

    // Reset asserted in RSP, then a fresh m1 transaction.
    @(negedge clk); drive(0,1,0,0,0,0, 32'h0, 0); #1;
    check("rst_accept", flags(), F_M1RR);
    @(negedge clk); drive(0,0,0,0,1,0, 32'h0, 0); #1;
    check("rst_req", flags(), F_SRV);
    @(negedge clk); drive(0,1,0,0,0,1, 32'h5A5A5A5A, 0); #1;
    check("rst_in_rsp", flags(), F_M1V);
    #2 rst = 1'b0; #1;
    check("rst_async_flags", flags(), 8'h00);
    check("rst_async_data", data(), 96'h0);
    @(negedge clk); #1;
    check("rst_held_flags", flags(), 8'h00);
    rst = 1'b1;
    drive(0,0,0,0,0,0, 32'h0, 0);
    @(negedge clk); drive(0,1,0,0,0,0, 32'h0, 0); #1;
    check("post_rst_accept", flags(), F_M1RR);
    @(negedge clk); drive(0,0,0,0,1,0, 32'h0, 0); #1;
    check("post_rst_req", data(), {32'h0, 32'h0, 32'h80001000});
    @(negedge clk); drive(0,0,0,1,0,1, 32'h5A5A5A5A, 0); #1;
    check("post_rst_rsp", flags(), F_SRR|F_M1V);
    check("post_rst_rdata", data(), {32'h0, 32'h5A5A5A5A, 32'h80001000});
    @(negedge clk); drive(0,0,0,0,0,0, 32'h0, 0); #1;
    check("post_rst_idle", flags(), 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
